clock_monitor: RTL

Checks the divided clocks produced by `clock_generator` against the master `clock`. It measures every high and low phase of `imem_clock`, `dmem_clock`, `processor_clock` and `regfile_clock` in master-clock cycles, then reports lock and fault status for each channel. It also drives a registered `sys_reset` to the processor core, which stays asserted until all four derived clocks are locked.

---
 rtl/clock_monitor_pkg.sv | 25 ++
 rtl/clock_monitor_clk_phase_checker.sv | 122 ++++++++++++
 rtl/clock_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// clock_monitor shared types and channel indices.
// Channel bit order in every 4-bit vector: {regfile, proc, dmem, imem}.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_t;

  localparam int CH_IMEM    = 0;
  localparam int CH_DMEM    = 1;
  localparam int CH_PROC    = 2;
  localparam int CH_REGFILE = 3;
  localparam int NUM_CH     = 4;

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    return 3'(v[0]) + 3'(v[1])
         + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/clock_monitor_clk_phase_checker.sv
// clk_phase_checker: measures every phase of one
// derived clock and tracks its lock/fault state.
module clk_phase_checker
  import clock_monitor_pkg::*;
#(
  parameter int HALF       = 2,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic clear_fault,
  output logic locked,
  output logic fault,
  output logic fault_pulse
);

  localparam int GR_W = $clog2(LOCK_COUNT + 1);
  localparam int LO   = (HALF > TOL) ? HALF - TOL : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HI_C =
    CNT_W'(HALF + TOL);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO);
  localparam logic [GR_W-1:0] LC_C =
    GR_W'(LOCK_COUNT);

  mon_state_t state, state_d;

  logic             s, p;
  logic             toggle;
  logic             phase_good;
  logic             stuck;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [GR_W-1:0]  good_run, good_run_d;
  logic [GR_W-1:0]  gr_inc;

  assign toggle = s ^ p;

  // cnt holds the measured phase length on a toggle
  assign phase_good = (cnt >= LO_C) && (cnt <= HI_C);

  // next edge would push the phase past its limit
  assign stuck = !toggle && (cnt >= HI_C);

  assign gr_inc = (good_run == LC_C)
                ? good_run
                : good_run + 1'b1;

  // sampler, phase counter and state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s        <= 1'b0;
      p        <= 1'b0;
      cnt      <= '0;
      good_run <= '0;
      state    <= ACQUIRE;
    end else begin
      s        <= clk_in;
      p        <= s;
      cnt      <= cnt_d;
      good_run <= good_run_d;
      state    <= state_d;
    end
  end

  // next-state, counter update and fault pulse
  always_comb begin
    state_d     = state;
    good_run_d  = good_run;
    fault_pulse = 1'b0;
    if (toggle) begin
      cnt_d = CNT_W'(1);
    end else if (cnt == CNT_MAX) begin
      cnt_d = cnt;
    end else begin
      cnt_d = cnt + 1'b1;
    end

    unique case (state)
      ACQUIRE: begin
        if (toggle) begin
          state_d    = LOCKING;
          good_run_d = '0;
        end
      end
      LOCKING, LOCKED: begin
        if (toggle) begin
          if (phase_good) begin
            good_run_d = gr_inc;
            if (gr_inc == LC_C) begin
              state_d = LOCKED;
            end
          end else begin
            state_d = FAULT;
          end
        end else if (stuck) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d    = ACQUIRE;
          cnt_d      = '0;
          good_run_d = '0;
        end
      end
      default: begin
        state_d = ACQUIRE;
      end
    endcase

    fault_pulse = (state != FAULT)
               && (state_d == FAULT);
  end

  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: lock/fault watch on the four derived
// clocks; CLOCK_MONITOR_FAULT_COUNT_EN adds fault_count.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int IMEM_HALF    = 1,
  parameter int DMEM_HALF    = 1,
  parameter int PROC_HALF    = 2,
  parameter int REGFILE_HALF = 2,
  parameter int TOL          = 0,
  parameter int LOCK_COUNT   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       imem_clock,
  input  logic       dmem_clock,
  input  logic       processor_clock,
  input  logic       regfile_clock,
  input  logic       clear_fault,
  output logic [3:0] locked,
  output logic [3:0] fault,
`ifdef CLOCK_MONITOR_FAULT_COUNT_EN
  output logic [7:0] fault_count,
`endif
  output logic       sys_reset
);

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] pulse;

  assign clk_vec[CH_IMEM]    = imem_clock;
  assign clk_vec[CH_DMEM]    = dmem_clock;
  assign clk_vec[CH_PROC]    = processor_clock;
  assign clk_vec[CH_REGFILE] = regfile_clock;

  clk_phase_checker #(
    .HALF       (IMEM_HALF),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_imem (
    .clock       (clock),
    .reset       (reset),
    .clk_in      (clk_vec[CH_IMEM]),
    .clear_fault (clear_fault),
    .locked      (locked[CH_IMEM]),
    .fault       (fault[CH_IMEM]),
    .fault_pulse (pulse[CH_IMEM])
  );

  clk_phase_checker #(
    .HALF       (DMEM_HALF),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_dmem (
    .clock       (clock),
    .reset       (reset),
    .clk_in      (clk_vec[CH_DMEM]),
    .clear_fault (clear_fault),
    .locked      (locked[CH_DMEM]),
    .fault       (fault[CH_DMEM]),
    .fault_pulse (pulse[CH_DMEM])
  );

  clk_phase_checker #(
    .HALF       (PROC_HALF),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_proc (
    .clock       (clock),
    .reset       (reset),
    .clk_in      (clk_vec[CH_PROC]),
    .clear_fault (clear_fault),
    .locked      (locked[CH_PROC]),
    .fault       (fault[CH_PROC]),
    .fault_pulse (pulse[CH_PROC])
  );

  clk_phase_checker #(
    .HALF       (REGFILE_HALF),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W)
  ) u_regfile (
    .clock       (clock),
    .reset       (reset),
    .clk_in      (clk_vec[CH_REGFILE]),
    .clear_fault (clear_fault),
    .locked      (locked[CH_REGFILE]),
    .fault       (fault[CH_REGFILE]),
    .fault_pulse (pulse[CH_REGFILE])
  );

  // hold the core in reset until every clock is locked
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sys_reset <= 1'b1;
    end else begin
      sys_reset <= ~&locked;
    end
  end

`ifdef CLOCK_MONITOR_FAULT_COUNT_EN
  logic [8:0] fc_sum;

  assign fc_sum = {1'b0, fault_count}
                + 9'(popcount4(pulse));

  // saturating count of entries into FAULT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_count <= '0;
    end else if (fc_sum[8]) begin
      fault_count <= 8'hFF;
    end else begin
      fault_count <= fc_sum[7:0];
    end
  end
`else
  logic unused_pulse;
  assign unused_pulse = ^pulse;
`endif

endmodule
